// File: rtl/sa_oport_if.sv
// Output-port allocator bus: requests and credits in, grant and crossbar select out.
interface sa_oport_if #(
  parameter int N  = 5,
  parameter int CW = 3
) ();
  logic [N-1:0]  reqSAIn;
  logic          creditIn;
  logic [N-1:0]  grantSA;
  logic [N-1:0]  xbarSelect;
  logic          xbarValid;
  logic [CW-1:0] creditCount;
  logic          creditOverflow;

  modport master (
    output reqSAIn,
    output creditIn,
    input  grantSA,
    input  xbarSelect,
    input  xbarValid,
    input  creditCount,
    input  creditOverflow
  );

  modport slave (
    input  reqSAIn,
    input  creditIn,
    output grantSA,
    output xbarSelect,
    output xbarValid,
    output creditCount,
    output creditOverflow
  );
endinterface

// File: rtl/sa_oport.sv
// Output-port stage of the separable switch allocator: credit-gated round-robin
// pick of one input port per cycle, plus the registered crossbar column select.
module sa_oport #(
  parameter int N          = 5,
  parameter int OPORT      = 0,
  parameter int CREDIT_MAX = 4
) (
  input logic       clk,
  input logic       rstn,
  sa_oport_if.slave sa
);
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);

  logic [N-1:0]  ptr;
  logic [N-1:0]  ptr_next;
  logic [N-1:0]  mask;
  logic [N-1:0]  req_hi;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          overflow;
  logic          overflow_next;
  logic [N-1:0]  xsel;
  logic          xvalid;

  // Ports at or above the pointer are searched first; lowest set bit wins,
  // otherwise wrap around and take the lowest requester overall.
  always_comb begin
    grant       = '0;
    mask        = ~(ptr - N'(1));
    req_hi      = sa.reqSAIn & mask;
    grant_valid = (|sa.reqSAIn) && (count != '0);
    if (grant_valid) begin
      if (|req_hi) begin
        grant = req_hi & (~req_hi + N'(1));
      end else begin
        grant = sa.reqSAIn & (~sa.reqSAIn + N'(1));
      end
    end
  end

  always_comb begin
    ptr_next      = ptr;
    count_next    = count;
    overflow_next = overflow;
    if (grant_valid) begin
      ptr_next = {grant[N-2:0], grant[N-1]};
    end
    case ({grant_valid, sa.creditIn})
      2'b10: count_next = count - CW'(1);
      2'b01: begin
        if (count == CMAX) begin
          overflow_next = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= N'(1);
      count    <= CMAX;
      overflow <= 1'b0;
      xsel     <= '0;
      xvalid   <= 1'b0;
    end else begin
      ptr      <= ptr_next;
      count    <= count_next;
      overflow <= overflow_next;
      xsel     <= grant;
      xvalid   <= |grant;
    end
  end

  assign sa.grantSA        = grant;
  assign sa.xbarSelect     = xsel;
  assign sa.xbarValid      = xvalid;
  assign sa.creditCount    = count;
  assign sa.creditOverflow = overflow;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(sa.grantSA));
  a_grant_subset: assert property (@(posedge clk) disable iff (!rstn) (sa.grantSA & ~sa.reqSAIn) == '0);
  a_credit_bound: assert property (@(posedge clk) disable iff (!rstn) count <= CMAX);
  a_oport_range:  assert property (@(posedge clk) disable iff (!rstn) (OPORT >= 0) && (OPORT < N));
endmodule

// File: tb/tb_sa_oport.sv
// Directed bench for sa_oport: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares grant, credit count and crossbar select.
module tb_sa_oport;
  typedef struct {
    logic [4:0] grant;
    logic [2:0] count;
  } exp_t;

  logic clk;
  logic rstn;
  int   n_compared;
  int   n_mismatched;
  exp_t exp_q[$];
  logic [4:0] xbar_q[$];

  sa_oport_if #(.N(5), .CW(3)) sa ();

  sa_oport #(.N(5), .OPORT(2), .CREDIT_MAX(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .sa  (sa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] req, input logic cin,
                               input logic [4:0] g, input logic [2:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    sa.reqSAIn  = req;
    sa.creditIn = cin;
    e.grant = g;
    e.count = c;
    exp_q.push_back(e);
  endtask

  // Monitor: crossbar select must echo the previous cycle's expected grant.
  initial begin
    exp_t e;
    logic [4:0] xs;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        xbar_q.delete();
      end else begin
        if (sa.xbarValid) begin
          if (xbar_q.size() == 0) begin
            checkOutput("xbar_unexpected", 8'(sa.xbarValid), 8'h0);
          end else begin
            xs = xbar_q.pop_front();
            checkOutput("xbarSelect", 8'(sa.xbarSelect), 8'(xs));
          end
        end else if (xbar_q.size() != 0) begin
          xs = xbar_q.pop_front();
          checkOutput("xbar_missing", 8'(sa.xbarValid), 8'h1);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("grantSA", 8'(sa.grantSA), 8'(e.grant));
          checkOutput("creditCount", 8'(sa.creditCount), 8'(e.count));
          if (e.grant != 5'b0) xbar_q.push_back(e.grant);
        end
      end
    end
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rstn         = 1'b0;
    sa.reqSAIn   = 5'b0;
    sa.creditIn  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_creditCount", 8'(sa.creditCount), 8'd4);
    checkOutput("rst_xbarValid", 8'(sa.xbarValid), 8'd0);
    checkOutput("rst_xbarSelect", 8'(sa.xbarSelect), 8'd0);
    checkOutput("rst_overflow", 8'(sa.creditOverflow), 8'd0);
    checkOutput("rst_grantSA", 8'(sa.grantSA), 8'd0);
    #1 rstn = 1'b1;
    $display("[TB] reset released");

    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd4);
    applyStimulus(5'b00100, 1'b0, 5'b00100, 3'd4);
    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd3);
    // Move the pointer back to port 0 and refill credits.
    applyStimulus(5'b10000, 1'b0, 5'b10000, 3'd3);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 3'd2);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 3'd3);

    applyStimulus(5'b11111, 1'b1, 5'b00001, 3'd4);
    applyStimulus(5'b11111, 1'b1, 5'b00010, 3'd4);
    applyStimulus(5'b11111, 1'b1, 5'b00100, 3'd4);
    applyStimulus(5'b11111, 1'b1, 5'b01000, 3'd4);
    applyStimulus(5'b11111, 1'b1, 5'b10000, 3'd4);
    applyStimulus(5'b11111, 1'b1, 5'b00001, 3'd4);
    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd4);
    applyStimulus(5'b10000, 1'b1, 5'b10000, 3'd4);

    applyStimulus(5'b00011, 1'b0, 5'b00001, 3'd4);
    applyStimulus(5'b00011, 1'b0, 5'b00010, 3'd3);
    applyStimulus(5'b00011, 1'b0, 5'b00001, 3'd2);
    applyStimulus(5'b00011, 1'b0, 5'b00010, 3'd1);
    applyStimulus(5'b00011, 1'b0, 5'b00000, 3'd0);
    applyStimulus(5'b00011, 1'b1, 5'b00000, 3'd0);
    applyStimulus(5'b00011, 1'b0, 5'b00001, 3'd1);
    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd0);

    applyStimulus(5'b00000, 1'b1, 5'b00000, 3'd0);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 3'd1);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 3'd2);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 3'd3);
    applyStimulus(5'b00000, 1'b1, 5'b00000, 3'd4);
    @(negedge clk);
    checkOutput("overflow_before", 8'(sa.creditOverflow), 8'd0);
    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd4);
    @(negedge clk);
    checkOutput("overflow_set", 8'(sa.creditOverflow), 8'd1);
    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd4);
    @(negedge clk);
    checkOutput("overflow_sticky", 8'(sa.creditOverflow), 8'd1);

    applyStimulus(5'b00001, 1'b0, 5'b00001, 3'd4);
    applyStimulus(5'b00010, 1'b0, 5'b00010, 3'd3);
    applyStimulus(5'b00100, 1'b0, 5'b00100, 3'd2);
    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_creditCount", 8'(sa.creditCount), 8'd4);
    checkOutput("midrst_xbarValid", 8'(sa.xbarValid), 8'd0);
    checkOutput("midrst_xbarSelect", 8'(sa.xbarSelect), 8'd0);
    checkOutput("midrst_overflow", 8'(sa.creditOverflow), 8'd0);
    @(negedge clk);
    #1 rstn = 1'b1;
    applyStimulus(5'b01001, 1'b0, 5'b00001, 3'd4);
    applyStimulus(5'b00000, 1'b0, 5'b00000, 3'd3);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0 || xbar_q.size() != 0) begin
      checkOutput("queues_drained", 8'(exp_q.size() + xbar_q.size()), 8'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
